// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the single-outstanding memory arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_MEM_LAT = 4;
endpackage

// File: rtl/rr_picker.sv
// Combinational picker: first asserted request at or after i_ptr (mod NUM_CH).
// With i_ptr tied to 0 this degenerates to lowest-index-wins fixed priority.
module rr_picker #(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = 1
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [IDX_W-1:0]  i_ptr,
  output logic [NUM_CH-1:0] o_gnt,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_any
);
  int w_c;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_c   = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_c = (int'(i_ptr) + k) % NUM_CH;
      if (!o_any && i_req[w_c]) begin
        o_any      = 1'b1;
        o_gnt[w_c] = 1'b1;
        o_idx      = IDX_W'(w_c);
      end
    end
  end
endmodule

// File: rtl/mem_arbiter_rr.sv
// Multi-channel memory arbiter, one transaction outstanding at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin; otherwise fixed priority (ch0 highest).
module mem_arbiter_rr
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MEM_LAT = DEF_MEM_LAT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req_en,
  input  logic [NUM_CH-1:0]        req_wr,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*DATA_W-1:0] req_wdata,
  output logic [NUM_CH-1:0]        req_valid,
  output logic [DATA_W-1:0]        rdata,
  output logic                     mem_en,
  output logic                     mem_wr,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     busy
);
  localparam int CNT_W = $clog2(MEM_LAT) + 1;
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [NUM_CH-1:0] r_gnt;
  logic [NUM_CH-1:0] w_gnt;
  logic [IDX_W-1:0]  w_idx;
  logic [IDX_W-1:0]  w_ptr;
  logic              w_any;
  logic              w_issue;

  assign w_issue = (r_state == IDLE) && w_any;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] r_ptr;
  assign w_ptr = r_ptr;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ptr <= '0;
    else if (w_issue)
      r_ptr <= (w_idx == IDX_W'(NUM_CH - 1)) ? '0 : w_idx + IDX_W'(1);
  end
`else
  assign w_ptr = '0;
`endif

  rr_picker #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_pick (
    .i_req (req_en),
    .i_ptr (w_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // DONE is the last waiting cycle; the registered req_valid lands one cycle
  // later, MEM_LAT cycles after mem_en, leaving IDLE free to reissue at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_gnt     <= '0;
      req_valid <= '0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      mem_en    <= 1'b0;
      req_valid <= '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_gnt     <= w_gnt;
            mem_en    <= 1'b1;
            mem_wr    <= req_wr[w_idx];
            mem_addr  <= req_addr[w_idx*ADDR_W +: ADDR_W];
            mem_wdata <= req_wdata[w_idx*DATA_W +: DATA_W];
            busy      <= 1'b1;
            r_cnt     <= CNT_LOAD;
            r_state   <= (MEM_LAT == 1) ? DONE : WAIT;
          end else begin
            busy <= 1'b0;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= DONE;
        end
        DONE: begin
          req_valid <= r_gnt;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // mem_wr stays latched through the completion cycle, so it qualifies rdata.
  assign rdata = (|req_valid && !mem_wr) ? mem_rdata : '0;
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr: MEM_LAT=4 instance plus a MEM_LAT=1 instance.
module tb_mem_arbiter_rr;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  logic [1:0]  req_en, req_wr, req_valid;
  logic [31:0] req_addr, req_wdata;
  logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_en, mem_wr, busy;

  logic [1:0]  req_en1, req_wr1, req_valid1;
  logic [31:0] req_addr1, req_wdata1;
  logic [15:0] rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic        mem_en1, mem_wr1, busy1;

  mem_arbiter_rr #(.NUM_CH(2), .ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst), .req_en(req_en), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_valid(req_valid), .rdata(rdata), .mem_en(mem_en),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy));

  mem_arbiter_rr #(.NUM_CH(2), .ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_en(req_en1), .req_wr(req_wr1), .req_addr(req_addr1),
    .req_wdata(req_wdata1), .req_valid(req_valid1), .rdata(rdata1), .mem_en(mem_en1),
    .mem_wr(mem_wr1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .busy(busy1));

  // Memory model: data presented only in the cycle exactly LAT after mem_en.
  logic [15:0] mem [0:255];
  int          k0 = 0;
  logic [15:0] a0 = '0;
  always @(posedge clk) begin
    if (mem_en) begin
      k0 <= 1;
      a0 <= mem_addr;
      if (mem_wr) mem[mem_addr[7:0]] <= mem_wdata;
    end else if (k0 != 0 && k0 < LAT) k0 <= k0 + 1;
    else k0 <= 0;
  end
  assign mem_rdata = (k0 == LAT) ? mem[a0[7:0]] : 16'hDEAD;

  int          k1 = 0;
  logic [15:0] a1 = '0;
  always @(posedge clk) begin
    if (mem_en1) begin
      k1 <= 1;
      a1 <= mem_addr1;
    end else k1 <= 0;
  end
  assign mem_rdata1 = (k1 == 1) ? (a1 ^ 16'h5A5A) : 16'hDEAD;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_issue(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_en && n < 20);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (req_valid == 2'b00 && n < 20);
  endtask

  typedef struct {
    int          ch;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
  } vec_t;
  vec_t tbl [7];

  logic [1:0] exp_seq [4];

  initial begin
    int n, ng, bad;
    rst = 1'b1;
    req_en = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    req_en1 = '0; req_wr1 = '0; req_addr1 = '0; req_wdata1 = '0;

    tbl[0] = '{0, 1'b1, 16'h0000, 16'hFFFF, 16'h0000};
    tbl[1] = '{0, 1'b0, 16'h0000, 16'h0000, 16'hFFFF};
    tbl[2] = '{1, 1'b1, 16'h0010, 16'hA5A5, 16'h0000};
    tbl[3] = '{0, 1'b0, 16'h0010, 16'h1111, 16'hA5A5};
    tbl[4] = '{1, 1'b0, 16'h0000, 16'h2222, 16'hFFFF};
    tbl[5] = '{0, 1'b1, 16'h0010, 16'h0001, 16'h0000};
    tbl[6] = '{1, 1'b0, 16'h0010, 16'h3333, 16'h0001};
`ifdef ARB_ROUND_ROBIN_EN
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
`else
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b01; exp_seq[2] = 2'b01; exp_seq[3] = 2'b01;
`endif

    // reset state
    repeat (2) @(negedge clk);
    chk("rst outs", {req_valid, mem_en, mem_wr, busy, rdata}, 0);
    chk("rst addr/wdata", {mem_addr, mem_wdata}, 0);
    chk("rst lat1 outs", {req_valid1, mem_en1, busy1, mem_addr1}, 0);
    rst = 1'b0;

    // idle
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (req_valid != 0 || mem_en || busy) bad++;
    end
    chk("idle quiet", bad, 0);

    // same-cycle conflict: ch0 write then ch1 read of the same address
    @(negedge clk);
    req_en = 2'b11; req_wr = 2'b01;
    req_addr = {16'h0002, 16'h0002}; req_wdata = {16'h7777, 16'h1234};
    wait_issue(n);
    chk("conflict first issue", mem_en, 1);
    chk("conflict first wr", mem_wr, 1);
    chk("conflict first wdata", mem_wdata, 16'h1234);
    wait_valid(n);
    chk("conflict first latency", n, LAT);
    chk("conflict first valid", req_valid, 2'b01);
    req_en[0] = 1'b0;
    @(negedge clk);
    chk("conflict back-to-back issue", mem_en, 1);
    chk("conflict second wr", mem_wr, 0);
    chk("conflict second addr", mem_addr, 16'h0002);
    wait_valid(n);
    chk("conflict second latency", n, LAT);
    chk("conflict second valid", req_valid, 2'b10);
    chk("conflict raw rdata", rdata, 16'h1234);
    req_en[1] = 1'b0;
    @(negedge clk);
    chk("conflict busy drop", {busy, mem_en}, 0);

    // single-channel transaction table
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      req_en[tbl[i].ch] = 1'b1;
      req_wr[tbl[i].ch] = tbl[i].wr;
      req_addr[tbl[i].ch*16 +: 16] = tbl[i].addr;
      req_wdata[tbl[i].ch*16 +: 16] = tbl[i].wdata;
      wait_issue(n);
      chk($sformatf("vec%0d issue", i), mem_en, 1);
      chk($sformatf("vec%0d mem_wr", i), mem_wr, tbl[i].wr);
      chk($sformatf("vec%0d mem_addr", i), mem_addr, tbl[i].addr);
      chk($sformatf("vec%0d mem_wdata", i), mem_wdata, tbl[i].wdata);
      chk($sformatf("vec%0d busy", i), busy, 1);
      wait_valid(n);
      chk($sformatf("vec%0d latency", i), n, LAT);
      chk($sformatf("vec%0d valid", i), req_valid, 2'b01 << tbl[i].ch);
      chk($sformatf("vec%0d rdata", i), rdata, tbl[i].exp_rd);
      chk($sformatf("vec%0d busy at done", i), busy, 1);
      req_en[tbl[i].ch] = 1'b0;
    end

    // both channels hold reads: grant order depends on arbitration mode
    @(negedge clk);
    req_en = 2'b11; req_wr = 2'b00; req_addr = {16'h0002, 16'h0000};
    ng = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_valid != 0) begin
        if (ng < 4) begin
          chk($sformatf("hold grant%0d", ng), req_valid, exp_seq[ng]);
          chk($sformatf("hold rdata%0d", ng), rdata,
              (exp_seq[ng] == 2'b10) ? 16'h1234 : 16'hFFFF);
        end
        ng++;
      end
    end
    req_en = 2'b00;
    chk("hold grant count", ng, 4);

    // reset two cycles into a transaction
    @(negedge clk);
    req_en[0] = 1'b1; req_wr[0] = 1'b0;
    req_addr[15:0] = 16'h0044; req_wdata[15:0] = 16'hBEEF;
    wait_issue(n);
    chk("rst-mid issue", mem_en, 1);
    chk("rst-mid wdata latched", mem_wdata, 16'hBEEF);
    repeat (2) @(negedge clk);
    req_en = 2'b00;
    #2 rst = 1'b1;
    #1;
    chk("rst-mid async outs", {req_valid, mem_en, mem_wr, busy, rdata}, 0);
    chk("rst-mid async addr/wdata", {mem_addr, mem_wdata}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (req_valid != 0 || mem_en) bad++;
    end
    chk("rst-mid no completion", bad, 0);
    @(negedge clk);
    req_en[1] = 1'b1; req_wr[1] = 1'b0; req_addr[31:16] = 16'h0002;
    wait_issue(n);
    chk("post-rst issue", mem_en, 1);
    chk("post-rst addr", mem_addr, 16'h0002);
    wait_valid(n);
    chk("post-rst latency", n, LAT);
    chk("post-rst valid", req_valid, 2'b10);
    chk("post-rst rdata", rdata, 16'h1234);
    req_en = 2'b00;

    // MEM_LAT=1 instance, ch1 read held high
    @(negedge clk);
    req_en1 = 2'b10; req_wr1 = 2'b00;
    req_addr1 = {16'h0002, 16'h0000}; req_wdata1 = {16'h3333, 16'h0000};
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_en1 && n < 20);
    chk("lat1 issue", mem_en1, 1);
    chk("lat1 issue fields", {mem_wr1, mem_addr1, mem_wdata1}, {1'b0, 16'h0002, 16'h3333});
    @(negedge clk);
    chk("lat1 valid", req_valid1, 2'b10);
    chk("lat1 rdata", rdata1, 16'h5A58);
    chk("lat1 busy/en at done", {busy1, mem_en1}, 2'b10);
    @(negedge clk);
    chk("lat1 reissue", mem_en1, 1);
    req_en1 = 2'b00;
    @(negedge clk);
    chk("lat1 second valid", req_valid1, 2'b10);
    @(negedge clk);
    chk("lat1 idle after", {busy1, mem_en1, req_valid1}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/mem_arbiter_rr.md
MEM_ARBITER_RR -- requirements
Module: mem_arbiter_rr

Interface
REQ-001 NUM_CH, 2, requester channel count (>=2); channel 0 is D-cache, channel 1 is I-cache.
REQ-002 ADDR_W, 16, address width in bits.
REQ-003 DATA_W, 16, data width in bits.
REQ-004 MEM_LAT, 4, memory cycles from issue to completion (>=1).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 req_en  input  NUM_CH  per-channel request, held high until that channel's req_valid.
REQ-008 req_wr  input  NUM_CH  per-channel write (1) / read (0).
REQ-009 req_addr  input  NUM_CH*ADDR_W  channel i at [i*ADDR_W +: ADDR_W].
REQ-010 req_wdata  input  NUM_CH*DATA_W  channel i at [i*DATA_W +: DATA_W].
REQ-011 req_valid  output  NUM_CH  one-cycle completion pulse, at most one bit set.
REQ-012 rdata  output  DATA_W  read data; meaningful only while a read's req_valid bit is high.
REQ-013 mem_en  output  1  one-cycle issue strobe to memory.
REQ-014 mem_wr  output  1  write qualifier, meaningful with mem_en.
REQ-015 mem_addr / mem_wdata  output  ADDR_W / DATA_W  latched transaction address / data, held stable while busy.
REQ-016 mem_rdata  input  DATA_W  memory read data, valid MEM_LAT cycles after issue.
REQ-017 busy  output  1  high from issue through the completion cycle.

Function
REQ-018 FSM states: IDLE, WAIT, DONE; exactly one transaction outstanding at a time.
REQ-019 IDLE with any req_en high: select a winner, latch its wr/addr/wdata/channel id, assert mem_en for 1 cycle, go to WAIT.
REQ-020 WAIT: down-counter loaded with MEM_LAT-1 at issue; go to DONE when the counter reaches 0 (MEM_LAT=1 goes straight to DONE).
REQ-021 DONE: req_valid[id]=1 for one cycle; rdata=mem_rdata for reads, 0 for writes; next state IDLE.
REQ-022 Issue cycle t yields req_valid in cycle t+MEM_LAT; the earliest next issue is t+MEM_LAT+1.
REQ-023 req_en, addr and data changes are ignored outside IDLE; latched values are used for the whole transaction.
REQ-024 req_en still high in IDLE after its own valid pulse is a new request and is arbitrated normally.
REQ-025 Counter width is $clog2(MEM_LAT)+1 bits; no wrap is permitted.
REQ-026 Read-after-write to the same address from any channel returns the written data; ordering is issue order.

Reset
REQ-027 rst forces IDLE, counter 0, rr pointer 0, and req_valid, rdata, mem_en, mem_wr, mem_addr, mem_wdata, busy all to 0.
REQ-028 rst mid-transaction abandons it: no req_valid pulse is produced, and the requester must re-request after reset.

Configuration
REQ-029 With ARB_ROUND_ROBIN_EN defined: the winner is the first asserted channel at or after the rr pointer (mod NUM_CH); the pointer becomes winner+1 at issue.
REQ-030 Without ARB_ROUND_ROBIN_EN: fixed priority, lowest asserted index wins (D-cache over I-cache), and no pointer state exists.

Structure
REQ-031 Shared package mem_arb_pkg holds the state enum (IDLE/WAIT/DONE) and default constants ADDR_W=16, DATA_W=16, MEM_LAT=4.
REQ-032 Sub-module rr_picker (NUM_CH requests plus pointer in, one-hot grant plus index out, combinational) holds the selection logic; the same module is used in fixed-priority mode with the pointer tied to 0.

Verification (NUM_CH=2, MEM_LAT=4, 20-unit clk period)
REQ-033 Idle: all req_en=0 for 10 cycles -> req_valid=0, mem_en=0, busy=0.
REQ-034 Ch0 write addr 0x0000 data 0xFFFF, then ch0 read 0x0000 -> write pulse 4 cycles after issue, then read req_valid[0] with rdata=0xFFFF.
REQ-035 Ch0 write 0x0002=0x1234 and ch1 read 0x0002 raised in the same cycle -> ch0 served first, then ch1 gets rdata=0x1234.
REQ-036 Both channels hold reads (ch0 0x0000, ch1 0x0002) for 20 cycles -> with macro, grants alternate 0,1,0,1; without macro, ch0 only.
REQ-037 rst asserted 2 cycles after issue -> outputs 0 asynchronously, no req_valid, next request issues normally after release.
REQ-038 MEM_LAT=1 build, ch1 read -> req_valid[1] one cycle after mem_en, next issue two cycles after the first.
